piso_tx: RTL and testbench
==========================

// Module: piso_tx
// PURPOSE
//   Parallel-in serial-out transmitter; the send-side counterpart of the SIPO receiver.
//   Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out one bit per clock.
//   A frame strobe marks valid serial bits, so serial_out/frame drive a SIPO's serial_in/ready directly.
//   A one-entry holding register allows back-to-back frames with no idle gap.
// PARAMETERS
//   WIDTH      8   bits per word; >= 2
//   LSB_FIRST  1   1: bit 0 sent first (matches SIPO receiver); 0: bit WIDTH-1 first
// PORTS
//   clk           in   1      single clock; all state updates on rising edge
//   rst           in   1      asynchronous, active-low reset (0 = reset)
//   in_valid      in   1      source presents a word on in_data
//   in_data       in   WIDTH  word to transmit; sampled only on handshake
//   in_ready      out  1      transmitter can accept a word this cycle
//   serial_out    out  1      serial data bit, registered
//   frame         out  1      high while serial_out carries a valid bit, registered
//   done          out  1      one-cycle pulse coincident with the last bit of each word, registered
// BEHAVIOUR
//   Reset (rst=0, async): serial_out=0, frame=0, done=0, state=IDLE, bit count=0, hold empty, in_ready=1.
//   Handshake: word accepted at the rising edge where in_valid && in_ready. in_ready = !hold_full
//     (derived from registered state only, no combinational path from in_valid).
//   FSM states: IDLE, SHIFT.
//   IDLE: serial_out=0, frame=0. On accept: in_data -> shift reg, first bit driven on serial_out,
//     frame=1, count=0, -> SHIFT. Latency: first bit visible the cycle after the accept edge.
//   SHIFT, count < WIDTH-1: each edge advance one bit, count++. An accept here writes the hold register.
//   SHIFT, count == WIDTH-1 (last bit on serial_out, done=1 this cycle). At the next edge:
//     - If the hold register is full: move hold -> shift reg, clear hold, count=0, stay in SHIFT.
//       Frame stays high, no gap.
//     - Else, if a word is accepted at that same edge: load it directly into the shift reg and stay in SHIFT.
//     - Else: go to IDLE with frame=0, serial_out=0.
//   done: high exactly one cycle per word. For back-to-back words, done is high on bit WIDTH-1
//     of word n only; it falls when bit 0 of word n+1 starts.
//   Hold full + in_valid: in_ready=0; the source holds the word. in_ready rises the cycle after the hold drains.
//   Simultaneous hold drain and new accept at the same edge is impossible (in_ready=0 while hold full).
//   Bit order: LSB_FIRST=1 sends shift_reg[0] and shifts right. LSB_FIRST=0 sends [WIDTH-1] and shifts left.
//   Count width: $clog2(WIDTH); counts 0..WIDTH-1 and never exceeds WIDTH-1.
//   Reset mid-frame: the frame aborts immediately. The hold word is discarded.
//     After release, the next accepted word starts at bit 0.
//   in_data is ignored outside the accept edge; it need not stay stable while shifting.
// STRUCTURE
//   Package piso_pkg: state enum {IDLE, SHIFT}; default WIDTH constant (8).
//   Sub-module piso_hold_reg: one-entry WIDTH-bit buffer with wr_en/rd_en and a full flag.
//   Top holds the FSM, bit counter, shift register and output registers.
// TESTING
//   1. rst=0 mid-simulation -> serial_out=0, frame=0, done=0, in_ready=1 without waiting for a clk edge.
//   2. One word 8'hCD (LSB_FIRST=1) -> serial_out 1,0,1,1,0,0,1,1 on cycles 1..8 after accept.
//      frame=1 for exactly those 8 cycles; done=1 on cycle 8 only; then IDLE.
//   3. 8'hA5 then 8'h3C with in_valid held -> second word enters hold on cycle 1; in_ready=0 until cycle 9.
//      16 contiguous frame cycles; done pulses on cycles 8 and 16.
//   4. Third word 8'hFF offered while hold full -> not accepted until in_ready returns.
//      Sent intact as the third frame.
//   5. Loopback into the SIPO receiver (serial_out->serial_in, frame->ready), send 8'b10110011
//      -> receiver parallel_out == 8'b10110011 when its done asserts.
//   6. rst=0 after bit 3 of 8'h5A with 8'h77 in hold -> outputs zero at once.
//      After release, send 8'h01 -> serial_out 1,0,0,0,0,0,0,0; 8'h77 is never sent.
//   LSB_FIRST=0 with 8'h80 -> serial_out 1 then seven 0s.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in serial-out transmitter.
`default_nettype none

package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage : piso_pkg

`default_nettype wire

// File: rtl/piso_hold_reg.sv
// One-entry word buffer that lets the next word wait while the current one shifts out.
`default_nettype none

module piso_hold_reg
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    // Write and read are never requested together: writes only happen while the buffer is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (wr_en_i) begin
            data_q <= wr_data_i;
            full_q <= 1'b1;
        end else if (rd_en_i) begin
            full_q <= 1'b0;
        end
    end

    assign rd_data_o = data_q;
    assign full_o    = full_q;

endmodule : piso_hold_reg

`default_nettype wire

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready input, frame strobe and last-bit pulse.
`default_nettype none

module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             serial_out_o,
    output logic             frame_o,
    output logic             done_o
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PEN_CNT  = CNT_W'(WIDTH - 2);

    piso_state_e      state_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] sreg_q;
    logic             frame_q;
    logic             done_q;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             accept;
    logic             last_bit;
    logic             hold_wr;
    logic             hold_rd;
    logic [WIDTH-1:0] sreg_shifted;
    logic [WIDTH-1:0] load_word;

    assign in_ready_o = !hold_full;
    assign accept     = in_valid_i && in_ready_o;
    assign last_bit   = (state_q == SHIFT) && (count_q == LAST_CNT);
    assign hold_wr    = accept && (state_q == SHIFT) && !last_bit;
    assign hold_rd    = last_bit && hold_full;
    assign load_word  = hold_full ? hold_data : in_data_i;

    piso_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (hold_wr),
        .wr_data_i (in_data_i),
        .rd_en_i   (hold_rd),
        .rd_data_o (hold_data),
        .full_o    (hold_full)
    );

    // The shift register's outgoing end is the serial output flop; it is zeroed when idle.
    if (LSB_FIRST) begin : g_lsb_first
        assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        assign serial_out_o = sreg_q[0];
    end else begin : g_msb_first
        assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        assign serial_out_o = sreg_q[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            sreg_q  <= '0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT;
                        sreg_q  <= in_data_i;
                        count_q <= '0;
                        frame_q <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        sreg_q  <= sreg_shifted;
                        count_q <= count_q + 1'b1;
                        done_q  <= (count_q == PEN_CNT);
                    end else if (hold_full || accept) begin
                        // Back-to-back word: frame stays high with no idle gap.
                        sreg_q  <= load_word;
                        count_q <= '0;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        sreg_q  <= '0;
                        count_q <= '0;
                        frame_q <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    sreg_q  <= '0;
                    count_q <= '0;
                    frame_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_o = frame_q;
    assign done_o  = done_q;

endmodule : piso_tx

`default_nettype wire

// File: tb/tb_piso_tx.sv
// Directed self-checking bench for piso_tx in both bit orders.
`default_nettype none

module tb_piso_tx;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       serial_out;
    logic       frame;
    logic       done;

    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       m_serial;
    logic       m_frame;
    logic       m_done;

    int n_cmp;
    int n_mis;

    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .serial_out_o (serial_out),
        .frame_o      (frame),
        .done_o       (done)
    );

    piso_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (m_valid),
        .in_data_i    (m_data),
        .in_ready_o   (m_ready),
        .serial_out_o (m_serial),
        .frame_o      (m_frame),
        .done_o       (m_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one active cycle c (1-based) of a contiguous multi-word stream.
    task automatic chk_bit(input string tag, input int c, input logic [31:0] bits);
        chk($sformatf("%s serial c%0d", tag, c), {31'd0, serial_out}, {31'd0, bits[c-1]});
        chk($sformatf("%s frame c%0d", tag, c), {31'd0, frame}, 32'd1);
        chk($sformatf("%s done c%0d", tag, c), {31'd0, done}, {31'd0, (c % 8) == 0});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " serial"}, {31'd0, serial_out}, 32'd0);
        chk({tag, " frame"}, {31'd0, frame}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] bits;
        logic [7:0]  rx_word;
        int          rx_cnt;
        bit          rx_seen;

        n_cmp    = 0;
        n_mis    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        m_valid  = 1'b0;
        m_data   = 8'h00;

        #2;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word 0xCD.
        in_valid = 1'b1;
        in_data  = 8'hCD;
        bits     = 32'h0000_00CD;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'h00;
            chk_bit("cd", c, bits);
        end
        @(negedge clk);
        chk_idle("cd end");

        // Two words back-to-back with valid held.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        bits     = 32'h0000_3CA5;
        @(negedge clk);
        chk("b2b ready c1", {31'd0, in_ready}, 32'd1);
        in_data = 8'h3C;
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 2) begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
            chk_bit("b2b", c, bits);
            if (c >= 2 && c <= 9)
                chk($sformatf("b2b ready c%0d", c), {31'd0, in_ready}, {31'd0, c == 9});
        end
        @(negedge clk);
        chk_idle("b2b end");

        // Third word offered while hold is full.
        in_valid = 1'b1;
        in_data  = 8'h12;
        bits     = 32'h00FF_3412;
        @(negedge clk);
        in_data = 8'h34;
        for (int c = 1; c <= 24; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 2)  in_data = 8'hFF;
            if (c == 10) begin
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
            chk_bit("three", c, bits);
            if (c >= 2 && c <= 9)
                chk($sformatf("three ready c%0d", c), {31'd0, in_ready}, {31'd0, c == 9});
        end
        @(negedge clk);
        chk_idle("three end");

        // Loopback into a behavioural LSB-first receiver.
        in_valid = 1'b1;
        in_data  = 8'b1011_0011;
        rx_word  = 8'h00;
        rx_cnt   = 0;
        rx_seen  = 1'b0;
        for (int c = 1; c <= 10 && !rx_seen; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'h00;
            if (frame) begin
                rx_word[rx_cnt[2:0]] = serial_out;
                rx_cnt++;
            end
            if (done) begin
                rx_seen = 1'b1;
                chk("loopback word", {24'd0, rx_word}, 32'h0000_00B3);
                chk("loopback count", rx_cnt, 32'd8);
            end
        end
        chk("loopback done seen", {31'd0, rx_seen}, 32'd1);
        @(negedge clk);

        // Reset mid-frame with a word waiting in hold.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(negedge clk);
        in_data = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("abort pre ready", {31'd0, in_ready}, 32'd0);
        chk("abort pre frame", {31'd0, frame}, 32'd1);
        chk("abort pre bit4", {31'd0, serial_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h01;
        bits     = 32'h0000_0001;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'h00;
            chk_bit("post", c, bits);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("no stale frame %0d", c), {31'd0, frame}, 32'd0);
        end

        // MSB-first instance.
        m_valid = 1'b1;
        m_data  = 8'h80;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            m_valid = 1'b0;
            m_data  = 8'h00;
            chk($sformatf("msb serial c%0d", c), {31'd0, m_serial}, {31'd0, c == 1});
            chk($sformatf("msb frame c%0d", c), {31'd0, m_frame}, 32'd1);
            chk($sformatf("msb done c%0d", c), {31'd0, m_done}, {31'd0, c == 8});
        end
        @(negedge clk);
        chk("msb end frame", {31'd0, m_frame}, 32'd0);
        chk("msb end ready", {31'd0, m_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_piso_tx

`default_nettype wire
